// File: rtl/cnt_tracker.sv
// Watches a counter/sub-counter pair, flags sequence and mismatch errors, counts wraps,
// and captures a coherent snapshot when an armed trigger value is seen.
module cnt_tracker #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  cnt_value,
  input  logic [WIDTH-1:0]  sub_cnt_value,
  input  logic              arm,
  input  logic [WIDTH-1:0]  trig_value,
  input  logic              snap_ready,
  input  logic              clr_err,
  output logic              snap_valid,
  output logic [WIDTH-1:0]  snap_cnt,
  output logic [WIDTH-1:0]  snap_sub,
  output logic [WRAP_W-1:0] snap_wraps,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_seq,
  output logic              err_mismatch,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
  localparam logic [ERR_W-1:0]  ERR_ONE  = 1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_cnt_q, prev_cnt_d;
  logic               prev_valid_q, prev_valid_d;
  logic               err_seq_q, err_seq_d;
  logic               err_mismatch_q, err_mismatch_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [WRAP_W-1:0]  wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0]   snap_cnt_q, snap_cnt_d;
  logic [WIDTH-1:0]   snap_sub_q, snap_sub_d;
  logic [WRAP_W-1:0]  snap_wraps_q, snap_wraps_d;

  logic seq_bad, mm_bad, any_bad, wrap_seen, capture;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prev_cnt_q     <= '0;
      prev_valid_q   <= 1'b0;
      err_seq_q      <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_count_q    <= '0;
      wrap_count_q   <= '0;
      snap_cnt_q     <= '0;
      snap_sub_q     <= '0;
      snap_wraps_q   <= '0;
    end else begin
      state_q        <= state_d;
      prev_cnt_q     <= prev_cnt_d;
      prev_valid_q   <= prev_valid_d;
      err_seq_q      <= err_seq_d;
      err_mismatch_q <= err_mismatch_d;
      err_count_q    <= err_count_d;
      wrap_count_q   <= wrap_count_d;
      snap_cnt_q     <= snap_cnt_d;
      snap_sub_q     <= snap_sub_d;
      snap_wraps_q   <= snap_wraps_d;
    end
  end

  // Checks run regardless of FSM state; a fresh error overrides a same-cycle clear.
  always_comb begin
    seq_bad      = prev_valid_q && (cnt_value != prev_cnt_q + CNT_ONE);
    mm_bad       = (cnt_value != sub_cnt_value);
    any_bad      = seq_bad || mm_bad;
    wrap_seen    = prev_valid_q && (prev_cnt_q == CNT_MAX) && (cnt_value == '0);
    prev_cnt_d   = cnt_value;
    prev_valid_d = 1'b1;
    wrap_count_d = wrap_seen ? wrap_count_q + WRAP_ONE : wrap_count_q;
    if (clr_err) begin
      err_seq_d      = seq_bad;
      err_mismatch_d = mm_bad;
      err_count_d    = any_bad ? ERR_ONE : '0;
    end else begin
      err_seq_d      = err_seq_q || seq_bad;
      err_mismatch_d = err_mismatch_q || mm_bad;
      err_count_d    = (any_bad && err_count_q != ERR_MAX) ? err_count_q + ERR_ONE : err_count_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    snap_cnt_d   = snap_cnt_q;
    snap_sub_d   = snap_sub_q;
    snap_wraps_d = snap_wraps_q;
    unique case (state_q)
      IDLE: if (arm) state_d = ARMED;
      ARMED: begin
        capture = (cnt_value == trig_value);
        if (capture) begin
          snap_cnt_d   = cnt_value;
          snap_sub_d   = sub_cnt_value;
          snap_wraps_d = wrap_count_q;
          state_d      = HOLD;
        end
      end
      HOLD: if (snap_ready) state_d = arm ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_valid   = (state_q == HOLD);
    busy         = (state_q != IDLE);
    snap_cnt     = snap_cnt_q;
    snap_sub     = snap_sub_q;
    snap_wraps   = snap_wraps_q;
    wrap_count   = wrap_count_q;
    err_count    = err_count_q;
    err_seq      = err_seq_q;
    err_mismatch = err_mismatch_q;
  end

endmodule

// File: tb/tb_cnt_tracker.sv
// Self-checking bench for cnt_tracker: per-feature tasks plus a snapshot scoreboard queue.
module tb_cnt_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cnt_value = '0;
  logic [7:0]  sub_cnt_value = '0;
  logic        arm = 1'b0;
  logic [7:0]  trig_value = '0;
  logic        snap_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic        snap_valid;
  logic [7:0]  snap_cnt;
  logic [7:0]  snap_sub;
  logic [15:0] snap_wraps;
  logic [15:0] wrap_count;
  logic [7:0]  err_count;
  logic        err_seq;
  logic        err_mismatch;
  logic        busy;

  typedef struct {
    logic [7:0]  c;
    logic [7:0]  s;
    logic [15:0] w;
  } snap_t;

  snap_t      snap_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_wraps = 0;
  logic [7:0] last_drv = '0;
  logic       last_valid = 1'b0;
  logic       prev_sv = 1'b0;
  logic [7:0] cur = '0;

  cnt_tracker #(.WIDTH(8), .WRAP_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_value(cnt_value), .sub_cnt_value(sub_cnt_value),
    .arm(arm), .trig_value(trig_value), .snap_ready(snap_ready), .clr_err(clr_err),
    .snap_valid(snap_valid), .snap_cnt(snap_cnt), .snap_sub(snap_sub),
    .snap_wraps(snap_wraps), .wrap_count(wrap_count), .err_count(err_count),
    .err_seq(err_seq), .err_mismatch(err_mismatch), .busy(busy)
  );

  always #5 clk = ~clk;

  // One sample per call; outputs are inspected 1ns after the edge, and a rising
  // snap_valid pops the oldest expected snapshot.
  task automatic drive(input logic [7:0] c, input logic [7:0] s);
    snap_t e;
    cnt_value     = c;
    sub_cnt_value = s;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_wraps  = 0;
      last_valid = 1'b0;
    end else begin
      if (last_valid && last_drv == 8'hFF && c == 8'h00) exp_wraps++;
      last_valid = 1'b1;
      last_drv   = c;
    end
    if (snap_valid && !prev_sv) begin
      n_checks++;
      if (snap_q.size() == 0) begin
        $display("[TB] FAIL snap_unexpected: snap_valid rose with cnt=%0h, expected no snapshot", snap_cnt);
      end else begin
        n_pass++;
        e = snap_q.pop_front();
        n_checks++;
        if (snap_cnt !== e.c) $display("[TB] FAIL snap_cnt: got %0h expected %0h", snap_cnt, e.c);
        else n_pass++;
        n_checks++;
        if (snap_sub !== e.s) $display("[TB] FAIL snap_sub: got %0h expected %0h", snap_sub, e.s);
        else n_pass++;
        n_checks++;
        if (snap_wraps !== e.w) $display("[TB] FAIL snap_wraps: got %0d expected %0d", snap_wraps, e.w);
        else n_pass++;
      end
    end
    prev_sv = snap_valid;
  endtask

  task automatic tick();
    drive(cur, cur);
    cur = cur + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(8'h33, 8'h44);
    drive(8'h35, 8'h46);
    n_checks++;
    if ({snap_valid, busy, err_seq, err_mismatch} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b expected 0000", {snap_valid, busy, err_seq, err_mismatch});
    else n_pass++;
    n_checks++;
    if ({wrap_count, err_count, snap_cnt, snap_sub, snap_wraps} !== '0)
      $display("[TB] FAIL reset_regs: wrap=%0d err=%0d snap=%0h/%0h/%0d expected all 0",
               wrap_count, err_count, snap_cnt, snap_sub, snap_wraps);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_count();
    cur = 8'h00;
    for (int i = 0; i < 256; i++) tick();
    n_checks++;
    if (wrap_count !== 16'd0) $display("[TB] FAIL wrap_before: got %0d expected 0", wrap_count);
    else n_pass++;
    tick();
    n_checks++;
    if (wrap_count !== 16'd1) $display("[TB] FAIL wrap_after: got %0d expected 1", wrap_count);
    else n_pass++;
    tick();
    n_checks++;
    if ({err_seq, err_mismatch, err_count} !== 10'd0)
      $display("[TB] FAIL clean_errors: seq=%b mm=%b cnt=%0d expected 0/0/0", err_seq, err_mismatch, err_count);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < 3; i++) begin
      drive(cur, cur + 8'd1);
      cur = cur + 8'd1;
    end
    tick();
    tick();
    n_checks++;
    if ({err_mismatch, err_seq, err_count} !== {1'b1, 1'b0, 8'd3})
      $display("[TB] FAIL mismatch_sticky: mm=%b seq=%b cnt=%0d expected 1/0/3", err_mismatch, err_seq, err_count);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++;
    if ({err_mismatch, err_seq, err_count} !== 10'd0)
      $display("[TB] FAIL clr_err: mm=%b seq=%b cnt=%0d expected 0/0/0", err_mismatch, err_seq, err_count);
    else n_pass++;
    clr_err = 1'b1;
    drive(cur, cur + 8'd1);
    cur = cur + 8'd1;
    clr_err = 1'b0;
    n_checks++;
    if ({err_mismatch, err_seq, err_count} !== {1'b1, 1'b0, 8'd1})
      $display("[TB] FAIL clr_vs_error: mm=%b seq=%b cnt=%0d expected 1/0/1", err_mismatch, err_seq, err_count);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_seq_and_saturation();
    while (cur != 8'd11) tick();
    drive(8'd12, 8'd12);
    drive(8'd12, 8'd12);
    cur = 8'd13;
    tick();
    n_checks++;
    if ({err_seq, err_mismatch, err_count} !== {1'b1, 1'b0, 8'd2})
      $display("[TB] FAIL seq_errors: seq=%b mm=%b cnt=%0d expected 1/0/2", err_seq, err_mismatch, err_count);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drive(cur, cur + 8'd1);
      cur = cur + 8'd1;
    end
    n_checks++;
    if (err_count !== 8'd255) $display("[TB] FAIL sat_reach: got %0d expected 255", err_count);
    else n_pass++;
    for (int i = 0; i < 45; i++) begin
      drive(cur, cur + 8'd1);
      cur = cur + 8'd1;
    end
    n_checks++;
    if ({err_count, err_mismatch} !== {8'd255, 1'b1})
      $display("[TB] FAIL sat_hold: cnt=%0d mm=%b expected 255/1", err_count, err_mismatch);
    else n_pass++;
    n_checks++;
    if (wrap_count !== 16'(exp_wraps)) $display("[TB] FAIL wrap_track: got %0d expected %0d", wrap_count, exp_wraps);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_snapshot();
    while (cur != 8'h30) tick();
    trig_value = 8'h40;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("[TB] FAIL armed_busy: got %b expected 1", busy);
    else n_pass++;
    while (cur != 8'h40) tick();
    n_checks++;
    if (snap_valid !== 1'b0) $display("[TB] FAIL snap_early: got %b expected 0", snap_valid);
    else n_pass++;
    snap_q.push_back('{8'h40, 8'h40, 16'(exp_wraps)});
    tick();
    n_checks++;
    if (snap_valid !== 1'b1) $display("[TB] FAIL snap_rise: got %b expected 1", snap_valid);
    else n_pass++;
    for (int i = 0; i < 256; i++) tick();
    n_checks++;
    if ({snap_valid, snap_cnt, snap_sub} !== {1'b1, 8'h40, 8'h40})
      $display("[TB] FAIL snap_stable: valid=%b cnt=%0h sub=%0h expected 1/40/40", snap_valid, snap_cnt, snap_sub);
    else n_pass++;
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    n_checks++;
    if ({snap_valid, busy, snap_cnt} !== {1'b0, 1'b0, 8'h40})
      $display("[TB] FAIL handshake_idle: valid=%b busy=%b cnt=%0h expected 0/0/40", snap_valid, busy, snap_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    trig_value = 8'h80;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    while (cur != 8'h80) tick();
    snap_q.push_back('{8'h80, 8'h80, 16'(exp_wraps)});
    tick();
    tick();
    trig_value = 8'h00;
    snap_ready = 1'b1;
    arm = 1'b1;
    tick();
    snap_ready = 1'b0;
    arm = 1'b0;
    n_checks++;
    if ({snap_valid, busy} !== 2'b01)
      $display("[TB] FAIL rearm: valid=%b busy=%b expected 0/1", snap_valid, busy);
    else n_pass++;
    while (cur != 8'h00) tick();
    snap_q.push_back('{8'h00, 8'h00, 16'(exp_wraps)});
    tick();
    n_checks++;
    if (snap_wraps + 16'd1 !== wrap_count)
      $display("[TB] FAIL wraps_before_inc: snap=%0d wrap=%0d expected snap=wrap-1", snap_wraps, wrap_count);
    else n_pass++;
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
  endtask

  task automatic test_arm_same_cycle();
    trig_value = cur;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    n_checks++;
    if ({snap_valid, busy} !== 2'b01)
      $display("[TB] FAIL arm_no_fire: valid=%b busy=%b expected 0/1", snap_valid, busy);
    else n_pass++;
    trig_value = cur + 8'd1;
    tick();
    snap_q.push_back('{cur, cur, 16'(exp_wraps)});
    tick();
    n_checks++;
    if (snap_valid !== 1'b1) $display("[TB] FAIL retarget: got %b expected 1", snap_valid);
    else n_pass++;
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig_value = cur;
    snap_q.push_back('{cur, cur, 16'(exp_wraps)});
    tick();
    n_checks++;
    if (snap_valid !== 1'b1) $display("[TB] FAIL hold_before_reset: got %b expected 1", snap_valid);
    else n_pass++;
    rst_n = 1'b0;
    drive(8'h77, 8'h12);
    rst_n = 1'b1;
    prev_sv = 1'b0;
    n_checks++;
    if ({snap_valid, busy, err_seq, err_mismatch, err_count, wrap_count, snap_cnt} !== '0)
      $display("[TB] FAIL reset_hold: valid=%b busy=%b seq=%b mm=%b err=%0d wrap=%0d snap=%0h expected all 0",
               snap_valid, busy, err_seq, err_mismatch, err_count, wrap_count, snap_cnt);
    else n_pass++;
    cur = 8'h55;
    tick();
    tick();
    n_checks++;
    if ({err_seq, err_count, busy} !== 10'd0)
      $display("[TB] FAIL first_sample: seq=%b err=%0d busy=%b expected 0/0/0", err_seq, err_count, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_count();
    test_mismatch();
    test_seq_and_saturation();
    test_snapshot();
    test_back_to_back();
    test_arm_same_cycle();
    test_reset_in_hold();
    n_checks++;
    if (snap_q.size() != 0) $display("[TB] FAIL snap_pending: %0d expected snapshots never seen", snap_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
